// File: rtl/cic_pkg.sv
// Shared CIC constants, used by both the integrator chain and the comb decimator.
// Keeps widths, decimation ratio and stage count in agreement across both ends.
package cic_pkg;

  localparam int CIC_WIDTH     = 18;
  localparam int CIC_WIDTH_OUT = 9;
  localparam int CIC_RATIO     = 8;
  localparam int CIC_STAGES    = 3;

  // Counter width for a 0..r-1 counter; never below one bit.
  function automatic int cnt_bits(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb (differentiator) stage with differential delay 1.
// Ports: clk, rst_n, in_valid/x in, out_valid/y out (y = x - previous x, modular).
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int WIDTH = CIC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        d <= x;
        y <= x - d;
      end
    end
  end

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC decimating comb section: downsample integrator output by RATIO,
// run STAGES comb stages, emit top WIDTH_OUT bits with a one-cycle valid_out.
module cic_comb_decimator
  import cic_pkg::*;
#(
  parameter int WIDTH_IN  = CIC_WIDTH,
  parameter int WIDTH_OUT = CIC_WIDTH_OUT,
  parameter int RATIO     = CIC_RATIO,
  parameter int STAGES    = CIC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH_IN-1:0]  data_in,
  input  logic                 sync_in,
  output logic [WIDTH_OUT-1:0] data_out,
  output logic                 valid_out
);

  localparam int CW = cnt_bits(RATIO);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  logic [CW-1:0]       cnt;
  logic                cap;
  logic [WIDTH_IN-1:0] s_x [0:STAGES];
  logic                s_v [0:STAGES];

  assign cap = (cnt == CNT_LAST);

  // sync only retargets the count; a capture on the same edge still fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sync_in || cap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_x[0] <= '0;
      s_v[0] <= 1'b0;
    end else begin
      s_v[0] <= cap;
      if (cap) begin
        s_x[0] <= data_in;
      end
    end
  end

  for (genvar k = 1; k <= STAGES; k++) begin : g_comb
    cic_comb_stage #(
      .WIDTH(WIDTH_IN)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (s_v[k-1]),
      .x        (s_x[k-1]),
      .out_valid(s_v[k]),
      .y        (s_x[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= s_v[STAGES];
      if (s_v[STAGES]) begin
        data_out <= s_x[STAGES][WIDTH_IN-1 -: WIDTH_OUT];
      end
    end
  end

endmodule
